// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the RV32 ALU control unit and its mul/div sequencer.
package alu_ctrl_pkg;

    localparam int ALU_CODE_W = 4;

    typedef enum logic [ALU_CODE_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Purely combinational ALUOp/funct3/funct7 decode plus RV32M detection.
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic       instr_valid,
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       op5,
    output alu_op_t    alu_code,
    output logic       is_md
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        alu_code = ALU_ADD;
        is_md    = instr_valid && (alu_op == ALUOP_FUNCT) && op5 && (funct7 == FUNCT7_MEXT);

        if (!is_md) begin
            case (alu_op)
                ALUOP_ADD:   alu_code = ALU_ADD;
                ALUOP_SUB:   alu_code = ALU_SUB;
                ALUOP_PASSB: alu_code = ALU_PASSB;
                default: begin
                    case (funct3)
                        3'b000:  alu_code = (op5 && funct7[5]) ? ALU_SUB : ALU_ADD;
                        3'b001:  alu_code = ALU_SLL;
                        3'b010:  alu_code = ALU_SLT;
                        3'b011:  alu_code = ALU_SLTU;
                        3'b100:  alu_code = ALU_XOR;
                        // Shift-immediates carry funct7[5] too, so op5 is not consulted here.
                        3'b101:  alu_code = funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  alu_code = ALU_OR;
                        default: alu_code = ALU_AND;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decode plus the multi-cycle sequencer that launches and tracks the mul/div unit.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W  = 4,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    input  logic                 flush,
    input  logic [1:0]           alu_op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 op5,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [2:0]           mem_ctrl,
    output logic                 md_start,
    output logic [2:0]           md_op,
    output logic                 md_busy,
    output logic                 md_done,
    output logic                 md_abort,
    output logic                 stall
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    alu_op_t    alu_code;
    logic       is_md;
    logic       start;
    md_state_t  state;
    logic [CNT_W-1:0] cnt;

    alu_op_decode u_decode (
        .instr_valid (instr_valid),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7      (funct7),
        .op5         (op5),
        .alu_code    (alu_code),
        .is_md       (is_md)
    );

    assign alu_ctrl = ALUCTRL_W'(alu_code);
    assign mem_ctrl = funct3;

    // Start is gated by rst_n so an M op held on the inputs cannot pulse md_start during reset.
    assign start    = rst_n && (state == MD_IDLE) && is_md && !flush;
    assign md_start = start;
    assign stall    = start || (state == MD_BUSY);
    assign md_busy  = (state != MD_IDLE);
    assign md_done  = (state == MD_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MD_IDLE;
            cnt      <= '0;
            md_op    <= '0;
            md_abort <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge snapshot.
            md_abort <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        state <= MD_BUSY;
                        md_op <= funct3;
                        cnt   <= funct3[2] ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (flush) begin
                        state    <= MD_IDLE;
                        md_abort <= 1'b1;
                    end else if (cnt == '0) begin
                        state <= MD_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                // The result is already valid in DONE, so a flush here needs no special handling.
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: a transaction-level model predicts decode and mul/div events.
module tb_alu_ctrl_seq;

    localparam int MUL_N = 2;
    localparam int DIV_N = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid, flush, op5;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu_ctrl;
    logic [2:0] mem_ctrl, md_op;
    logic       md_start, md_busy, md_done, md_abort, stall;

    alu_ctrl_seq #(
        .ALUCTRL_W  (4),
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .flush       (flush),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7      (funct7),
        .op5         (op5),
        .alu_ctrl    (alu_ctrl),
        .mem_ctrl    (mem_ctrl),
        .md_start    (md_start),
        .md_op       (md_op),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .md_abort    (md_abort),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct { bit abort; logic [2:0] op; int at; } ev_t;
    typedef struct { logic start; logic stall; logic busy; logic [3:0] alu; logic [2:0] mem; } cyc_t;

    ev_t  ev_q[$];
    cyc_t cyc_q[$];

    // Model state: one op in flight, described by its start cycle and BUSY length.
    bit op_active = 1'b0;
    int op_start  = 0;
    int op_n      = 0;

    function automatic logic [3:0] ref_alu(logic [1:0] aop, logic [2:0] f3, logic [6:0] f7, logic p5);
        if (aop == 2'b00) return 4'd0;
        if (aop == 2'b01) return 4'd1;
        if (aop == 2'b11) return 4'd10;
        case (f3)
            3'd0:    return (p5 && f7[5]) ? 4'd1 : 4'd0;
            3'd1:    return 4'd6;
            3'd2:    return 4'd5;
            3'd3:    return 4'd9;
            3'd4:    return 4'd4;
            3'd5:    return f7[5] ? 4'd8 : 4'd7;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    task automatic drive_cycle(logic v, logic fl, logic [1:0] aop, logic [2:0] f3, logic [6:0] f7, logic p5);
        cyc_t e;
        ev_t  ev;
        bit   md;
        int   k;
        instr_valid = v;
        flush       = fl;
        alu_op      = aop;
        funct3      = f3;
        funct7      = f7;
        op5         = p5;
        md      = v && (aop == 2'b10) && p5 && (f7 == 7'h01);
        e.start = 1'b0;
        e.stall = 1'b0;
        e.busy  = 1'b0;
        e.alu   = md ? 4'd0 : ref_alu(aop, f3, f7, p5);
        e.mem   = f3;
        if (op_active) begin
            e.busy = 1'b1;
            k = cyc - op_start;
            if (k <= op_n) begin
                e.stall = 1'b1;
                if (fl) begin
                    ev       = ev_q.pop_back();
                    ev.abort = 1'b1;
                    ev.at    = cyc + 1;
                    ev_q.push_back(ev);
                    op_active = 1'b0;
                end
            end else begin
                op_active = 1'b0;
            end
        end else if (md && !fl) begin
            e.start   = 1'b1;
            e.stall   = 1'b1;
            op_active = 1'b1;
            op_start  = cyc;
            op_n      = f3[2] ? DIV_N : MUL_N;
            ev.abort  = 1'b0;
            ev.op     = f3;
            ev.at     = cyc + op_n + 1;
            ev_q.push_back(ev);
        end
        cyc_q.push_back(e);
    endtask

    task automatic step(logic v, logic fl, logic [1:0] aop, logic [2:0] f3, logic [6:0] f7, logic p5);
        @(posedge clk);
        #1;
        drive_cycle(v, fl, aop, f3, f7, p5);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 3'd0, 7'd0, 1'b0);
    endtask

    // Asserts reset mid-cycle while an op is running; the op vanishes without any event.
    task automatic reset_mid_op();
        cyc_t e;
        ev_t  ev;
        instr_valid = 1'b0;
        flush       = 1'b0;
        alu_op      = 2'b00;
        funct3      = 3'd0;
        funct7      = 7'd0;
        op5         = 1'b0;
        e.start = 1'b0;
        e.stall = 1'b0;
        e.busy  = 1'b0;
        e.alu   = 4'd0;
        e.mem   = 3'd0;
        cyc_q.push_back(e);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_md_busy",  md_busy,  0);
        check("rst_mid_stall",    stall,    0);
        check("rst_mid_md_start", md_start, 0);
        check("rst_mid_md_done",  md_done,  0);
        check("rst_mid_md_abort", md_abort, 0);
        check("rst_mid_md_op",    md_op,    0);
        check("rst_mid_alu_ctrl", alu_ctrl, 0);
        if (op_active) begin
            ev = ev_q.pop_back();
            op_active = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(1'b0, 1'b0, 2'b00, 3'd0, 7'd0, 1'b0);
    endtask

    cyc_t mon_e;
    ev_t  mon_ev;

    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mon_e = cyc_q.pop_front();
            check("md_start", md_start, mon_e.start);
            check("stall",    stall,    mon_e.stall);
            check("md_busy",  md_busy,  mon_e.busy);
            check("alu_ctrl", alu_ctrl, mon_e.alu);
            check("mem_ctrl", mem_ctrl, mon_e.mem);
        end
        if (md_done || md_abort) begin
            if (ev_q.size() == 0) begin
                check("unexpected_done_abort", {md_done, md_abort}, 0);
            end else begin
                mon_ev = ev_q.pop_front();
                check("md_done",     md_done,  !mon_ev.abort);
                check("md_abort",    md_abort, mon_ev.abort);
                check("md_op",       md_op,    mon_ev.op);
                check("event_cycle", cyc,      mon_ev.at);
            end
        end else if (ev_q.size() > 0 && ev_q[0].at <= cyc) begin
            mon_ev = ev_q.pop_front();
            check("missing_done_abort", {md_done, md_abort}, mon_ev.abort ? 2'b01 : 2'b10);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] f7;
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        flush       = 1'b0;
        alu_op      = 2'b10;
        funct3      = 3'd0;
        funct7      = 7'h01;
        op5         = 1'b1;
        #3;
        check("rst_md_start", md_start, 0);
        check("rst_stall",    stall,    0);
        check("rst_md_busy",  md_busy,  0);
        check("rst_md_done",  md_done,  0);
        check("rst_md_abort", md_abort, 0);
        check("rst_md_op",    md_op,    0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_cycle(1'b0, 1'b0, 2'b00, 3'd0, 7'd0, 1'b0);

        // Decode sweep.
        step(1'b1, 1'b0, 2'b10, 3'd0, 7'h20, 1'b1);
        step(1'b1, 1'b0, 2'b10, 3'd5, 7'h20, 1'b1);
        step(1'b1, 1'b0, 2'b10, 3'd0, 7'h20, 1'b0);
        step(1'b1, 1'b0, 2'b10, 3'd3, 7'h20, 1'b1);
        step(1'b1, 1'b0, 2'b11, 3'd0, 7'h20, 1'b1);
        step(1'b1, 1'b0, 2'b10, 3'd5, 7'h00, 1'b0);

        // MUL, then MUL with a flush landing in DONE.
        step(1'b1, 1'b0, 2'b10, 3'd0, 7'h01, 1'b1);
        idle(4);
        step(1'b1, 1'b0, 2'b10, 3'd3, 7'h01, 1'b1);
        idle(2);
        step(1'b0, 1'b1, 2'b00, 3'd0, 7'd0, 1'b0);
        idle(2);

        // Back-to-back DIVs held on the inputs.
        for (int i = 0; i < 68; i++) step(1'b1, 1'b0, 2'b10, 3'd4, 7'h01, 1'b1);
        idle(2);

        // Flush at BUSY cycle 5 of a DIV.
        step(1'b1, 1'b0, 2'b10, 3'd4, 7'h01, 1'b1);
        idle(4);
        step(1'b0, 1'b1, 2'b00, 3'd0, 7'd0, 1'b0);
        idle(3);

        // Reset at BUSY cycle 3 of a DIV.
        step(1'b1, 1'b0, 2'b10, 3'd6, 7'h01, 1'b1);
        idle(2);
        @(posedge clk);
        #1;
        reset_mid_op();
        idle(5);

        // Flush coincident with an M op in IDLE.
        step(1'b1, 1'b1, 2'b10, 3'd0, 7'h01, 1'b1);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0,
                 ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)),
                 f7,
                 1'($urandom_range(0, 1)));
        end

        idle(40);
        @(negedge clk);
        #1;
        check("scoreboard_drained", ev_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Second-generation ALU control unit for the RV32 core.
- Combinationally decodes ALUOp/funct3/funct7 into a widened ALU control code, adding SRA, SLTU and a PASSB (LUI) op.
- Also detects RV32M instructions and runs a parametrised multi-cycle sequencer that starts the external mul/div unit, stalls the pipeline and reports completion or abort.
- Sits between the main decoder and the execute stage, replacing the single-cycle ALU decoder.

Parameters:
- ALUCTRL_W, 4: width of alu_ctrl; must be >= 4.
- MUL_CYCLES, 2: BUSY cycles for funct3[2]=0 ops (MUL/MULH/MULHSU/MULHU); range 1..255.
- DIV_CYCLES, 32: BUSY cycles for funct3[2]=1 ops (DIV/DIVU/REM/REMU); range 1..255.
- CNT_W, 8: width of the sequencer down-counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- instr_valid  in  1  decode stage holds a valid instruction.
- flush  in  1  pipeline flush (branch/jump redirect).
- alu_op  in  2  main-decoder ALUOp.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- op5  in  1  opcode bit 5 (1 = R-type).
- alu_ctrl  out  ALUCTRL_W  ALU operation code (combinational).
- mem_ctrl  out  3  funct3 passthrough for data-memory width/sign.
- md_start  out  1  one-cycle pulse that launches the mul/div unit.
- md_op  out  3  registered funct3 of the running M op.
- md_busy  out  1  sequencer not IDLE.
- md_done  out  1  one-cycle pulse: result valid this cycle.
- md_abort  out  1  one-cycle pulse: running op cancelled by flush.
- stall  out  1  hold fetch/decode (combinational).

Behaviour:
- Encodings (zero-extended to ALUCTRL_W): ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLL 6, SRL 7, SRA 8, SLTU 9, PASSB 10.
- Decode priority:
  - alu_op=00 -> ADD.
  - alu_op=01 -> SUB.
  - alu_op=11 -> PASSB.
  - alu_op=10, by funct3:
    - 000: SUB if op5&funct7[5], else ADD.
    - 001: SLL.
    - 010: SLT.
    - 011: SLTU.
    - 100: XOR.
    - 101: SRA if funct7[5], else SRL. Applies to R-type and I-type shifts.
    - 110: OR.
    - 111: AND.
- mem_ctrl = funct3 at all times.
- is_md = instr_valid & alu_op==10 & op5 & funct7==7'b0000001. When is_md, alu_ctrl is don't-care; drive ADD.
- FSM states IDLE, BUSY, DONE; down-counter cnt.
- IDLE:
  - Entry condition: is_md & !flush.
  - On entry: md_start=1 (combinational), stall=1.
  - Next edge: state<=BUSY, md_op<=funct3, cnt<=(funct3[2] ? DIV_CYCLES : MUL_CYCLES)-1.
- BUSY:
  - stall=1.
  - If cnt==0, next state is DONE; else cnt<=cnt-1.
  - Exactly N cycles in BUSY.
- DONE:
  - md_done=1, stall=0; pipeline advances this cycle.
  - Next state IDLE unconditionally; no new start is accepted in DONE.
  - Back-to-back M ops therefore begin in the following IDLE cycle.
- Latency: md_done is asserted N+1 cycles after the md_start cycle. Stall spans N+1 cycles.
- Flush:
  - In BUSY or DONE, flush forces IDLE next edge.
  - If flush arrives in BUSY, md_abort pulses next cycle and md_done is never raised for that op.
  - flush in IDLE suppresses the start.
  - flush in DONE: md_done still pulses (result already valid), no abort.
- md_busy = (state!=IDLE).
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, md_op=0, md_abort=0.
  - Consequently md_done=0, md_busy=0, md_start=0, stall=0 regardless of inputs.
  - Reset mid-operation drops the op silently, with no abort pulse.
- Release is synchronous to clk via standard reset synchroniser upstream.

Decomposition:
- Package alu_ctrl_pkg:
  - ALU op encoding localparams/enum (ALU_ADD..ALU_PASSB).
  - ALUOP_* constants.
  - FUNCT7_MEXT = 7'b0000001.
  - md_state_t enum.
- Sub-module alu_op_decode: the purely combinational alu_ctrl/is_md decode, reused by a future dual-issue decoder.
- The sequencer lives in alu_ctrl_seq.

Test Plan:
- ALU decode sweep: alu_op=10, op5=1, funct7=0100000.
  - funct3=000 -> SUB (1).
  - funct3=101 -> SRA (8).
  - With op5=0, funct3=000 -> ADD (0).
  - funct3=011 -> SLTU (9).
  - alu_op=11 -> PASSB (10).
- MUL: funct3=000, funct7=0000001, MUL_CYCLES=2.
  - md_start at cycle 0.
  - stall high for cycles 0–2.
  - md_done at cycle 3.
  - md_op=000.
- DIV with DIV_CYCLES=32, funct3=100:
  - stall for 33 cycles.
  - md_done at cycle 33.
  - A second DIV presented immediately starts at cycle 34 with md_start=1.
- Flush at BUSY cycle 5 of a DIV:
  - md_abort=1 at cycle 6, state IDLE.
  - No md_done.
  - stall low at cycle 6.
- rst_n low at BUSY cycle 3 (asynchronous, mid-clock):
  - All outputs 0 immediately.
  - After release with instr_valid=0, stays IDLE.
- Flush coincident with is_md in IDLE: no md_start, stall=0, state stays IDLE.
